// File: rtl/noc_packetizer_if.sv
// noc_packetizer_if
//   Bundles the two handshake links of the packetizer:
//     client link : in_data, in_dest, in_last, in_valid -> in_ready
//     router link : data_out, dest_out, is_tail_out, send_out -> credit_in
//   master : packetizer view (accepts client flits, drives the router link)
//   slave  : environment view (client source plus router input port)
interface noc_packetizer_if #(
  parameter int FLIT_WIDTH = 256,
  parameter int DEST_WIDTH = 3
);
  logic [FLIT_WIDTH-1:0] in_data;
  logic [DEST_WIDTH-1:0] in_dest;
  logic                  in_last;
  logic                  in_valid;
  logic                  in_ready;
  logic [FLIT_WIDTH-1:0] data_out;
  logic [DEST_WIDTH-1:0] dest_out;
  logic                  is_tail_out;
  logic                  send_out;
  logic                  credit_in;

  modport master (
    input  in_data, in_dest, in_last, in_valid, credit_in,
    output in_ready, data_out, dest_out, is_tail_out, send_out
  );

  modport slave (
    output in_data, in_dest, in_last, in_valid, credit_in,
    input  in_ready, data_out, dest_out, is_tail_out, send_out
  );
endinterface

// File: rtl/noc_packetizer.sv
// noc_packetizer
//   Injection-side network interface for one NoC router input port.
//   Accepts client flits over valid/ready, latches the destination on the
//   head flit, caps packets at MAX_PACKET_FLITS (forcing a tail and flagging
//   split_err), and only accepts a flit while a downstream credit is held.
//   Ports:
//     clk, rst_n  : clock, synchronous active-low reset
//     bus         : noc_packetizer_if.master (client link + router link)
//     split_err   : sticky, a packet was split at the length limit
//     credit_err  : sticky, credit returned while counter already full
//     pkt_count   : tail flits sent   (stats build only, else 0)
//     flit_count  : flits sent        (stats build only, else 0)
//   Build option: define NOC_PACKETIZER_STATS_EN to enable the counters.
//
//   state | meaning
//   HEAD  | next accepted flit starts a packet, in_dest is taken
//   BODY  | inside a packet, destination held in dest_reg
module noc_packetizer #(
  parameter int FLIT_WIDTH        = 256,
  parameter int DEST_WIDTH        = 3,
  parameter int FLIT_BUFFER_DEPTH = 2,
  parameter int MAX_PACKET_FLITS  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  noc_packetizer_if.master    bus,
  output logic                split_err,
  output logic                credit_err,
  output logic [31:0]         pkt_count,
  output logic [31:0]         flit_count
);
  localparam int CW = $clog2(FLIT_BUFFER_DEPTH) + 1;
  localparam int LW = $clog2(MAX_PACKET_FLITS) + 1;

  typedef enum logic {HEAD, BODY} state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         credits;
  logic [LW-1:0]         len, len_nx;
  logic [DEST_WIDTH-1:0] dest_reg, head_dest;
  logic                  accept, tail;

  // Reset gates in_ready so no flit is offered a handshake during reset.
  assign bus.in_ready = rst_n && (credits != '0);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credits    <= CW'(FLIT_BUFFER_DEPTH);
      credit_err <= 1'b0;
    end else if (bus.credit_in && !accept && credits == CW'(FLIT_BUFFER_DEPTH)) begin
      credit_err <= 1'b1;
    end else begin
      credits <= credits + CW'(bus.credit_in) - CW'(accept);
    end
  end

  always_comb begin
    state_nx  = state;
    len_nx    = len;
    tail      = 1'b0;
    head_dest = bus.in_dest;
    case (state)
      HEAD: begin
        tail = bus.in_last || (MAX_PACKET_FLITS == 1);
        if (accept) begin
          len_nx = LW'(1);
          if (!tail) state_nx = BODY;
        end
      end
      BODY: begin
        head_dest = dest_reg;
        tail      = bus.in_last || (len + LW'(1) == LW'(MAX_PACKET_FLITS));
        if (accept) begin
          len_nx = len + LW'(1);
          if (tail) state_nx = HEAD;
        end
      end
      default: state_nx = HEAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= HEAD;
      len             <= '0;
      dest_reg        <= '0;
      split_err       <= 1'b0;
      bus.data_out    <= '0;
      bus.dest_out    <= '0;
      bus.is_tail_out <= 1'b0;
      bus.send_out    <= 1'b0;
    end else begin
      state        <= state_nx;
      len          <= len_nx;
      bus.send_out <= accept;
      if (accept) begin
        dest_reg        <= head_dest;
        bus.data_out    <= bus.in_data;
        bus.dest_out    <= head_dest;
        bus.is_tail_out <= tail;
        if (tail && !bus.in_last) split_err <= 1'b1;
      end
    end
  end

`ifdef NOC_PACKETIZER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_count  <= '0;
      flit_count <= '0;
    end else if (bus.send_out) begin
      flit_count <= flit_count + 32'd1;
      if (bus.is_tail_out) pkt_count <= pkt_count + 32'd1;
    end
  end
`else
  assign pkt_count  = '0;
  assign flit_count = '0;
`endif
endmodule
